// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: issues commands to the ALU, holds operands SETTLE cycles, returns the captured result and flags
module alu_cmd_sequencer #(
  parameter int WIDTH  = 16,
  parameter int OPW    = 3,
  parameter int SETTLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OPW-1:0]   cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_chain,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_co,
  input  logic             alu_overflow,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [3:0]       rsp_flags,
  output logic [3:0]       sticky_flags,
  input  logic             clr_sticky,
  output logic [15:0]      op_count
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  state_t state_q, state_d;
  logic cmd_ready_q, cmd_ready_d, rsp_valid_q, rsp_valid_d, cap;
  logic [3:0] cnt_q, cnt_d, rsp_flags_q, rsp_flags_d, sticky_q, sticky_d, new_flags;
  logic [OPW-1:0] op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, last_q, last_d;
  logic [15:0] op_count_q, op_count_d;
  assign new_flags = {alu_overflow, alu_co, alu_zero, alu_result[WIDTH-1]};
  always_comb begin
    state_d = state_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    cnt_d = cnt_q;
    op_d = op_q;
    a_d = a_q;
    b_d = b_q;
    res_d = res_q;
    last_d = last_q;
    rsp_flags_d = rsp_flags_q;
    op_count_d = op_count_q;
    cap = 1'b0;
    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          op_d = cmd_op;
          a_d = cmd_chain ? last_q : cmd_a;
          b_d = cmd_b;
          cnt_d = 4'(SETTLE - 1);
          cmd_ready_d = 1'b0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
        else begin
          cap = 1'b1;
          res_d = alu_result;
          last_d = alu_result;
          rsp_flags_d = new_flags;
          op_count_d = op_count_q + 16'd1;
          rsp_valid_d = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    sticky_d = (clr_sticky ? 4'h0 : sticky_q) | (cap ? new_flags : 4'h0);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      cnt_q <= '0;
      op_q <= '0;
      a_q <= '0;
      b_q <= '0;
      res_q <= '0;
      last_q <= '0;
      rsp_flags_q <= '0;
      sticky_q <= '0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      cnt_q <= cnt_d;
      op_q <= op_d;
      a_q <= a_d;
      b_q <= b_d;
      res_q <= res_d;
      last_q <= last_d;
      rsp_flags_q <= rsp_flags_d;
      sticky_q <= sticky_d;
      op_count_q <= op_count_d;
    end
  end
  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign alu_op = op_q;
  assign alu_a = a_q;
  assign alu_b = b_q;
  assign rsp_result = res_q;
  assign rsp_flags = rsp_flags_q;
  assign sticky_flags = sticky_q;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// tb_alu_cmd_sequencer: directed stimulus with a transaction-level model checked every cycle
module tb_alu_cmd_sequencer;
  localparam int S = 1;
  logic clk = 0, rst_n = 0;
  always #5 clk = ~clk;
  logic cmd_valid = 0, cmd_chain = 0, rsp_ready = 0, clr_sticky = 0, preload = 0;
  logic [2:0] cmd_op = 0;
  logic [15:0] cmd_a = 0, cmd_b = 0;
  logic cmd_ready, rsp_valid, alu_co, alu_overflow, alu_zero;
  logic [2:0] alu_op;
  logic [15:0] alu_a, alu_b, alu_result, rsp_result, op_count;
  logic [3:0] rsp_flags, sticky_flags;
  int n_tests = 0, n_fail = 0;

  function automatic logic [18:0] alu_f(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic ovf;
    ovf = 1'b0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; ovf = (a[15] == b[15]) && (s[15] != a[15]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; ovf = (a[15] != b[15]) && (s[15] != a[15]); end
      3'd2: s = {1'b0, a & b};
      3'd3: s = {1'b0, a | b};
      default: s = {1'b0, a ^ b};
    endcase
    return {ovf, s[16], s[15:0] == 16'd0, s[15:0]};
  endfunction

  assign {alu_overflow, alu_co, alu_zero, alu_result} = alu_f(alu_op, alu_a, alu_b);

  alu_cmd_sequencer #(.WIDTH(16), .OPW(3), .SETTLE(S)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain), .alu_op(alu_op), .alu_a(alu_a),
    .alu_b(alu_b), .alu_result(alu_result), .alu_co(alu_co), .alu_overflow(alu_overflow),
    .alu_zero(alu_zero), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .sticky_flags(sticky_flags), .clr_sticky(clr_sticky), .op_count(op_count));

  logic s3_valid = 0, s3_ready, s3_rvalid, s3_co, s3_ovf, s3_zero;
  logic [2:0] s3_op = 0, s3_alu_op;
  logic [15:0] s3_a = 0, s3_b = 0, s3_alu_a, s3_alu_b, s3_res, s3_rsp, s3_cnt;
  logic [3:0] s3_flags, s3_sticky;
  assign {s3_ovf, s3_co, s3_zero, s3_res} = alu_f(s3_alu_op, s3_alu_a, s3_alu_b);

  alu_cmd_sequencer #(.WIDTH(16), .OPW(3), .SETTLE(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(s3_valid), .cmd_ready(s3_ready), .cmd_op(s3_op),
    .cmd_a(s3_a), .cmd_b(s3_b), .cmd_chain(1'b0), .alu_op(s3_alu_op), .alu_a(s3_alu_a),
    .alu_b(s3_alu_b), .alu_result(s3_res), .alu_co(s3_co), .alu_overflow(s3_ovf),
    .alu_zero(s3_zero), .rsp_valid(s3_rvalid), .rsp_ready(1'b0), .rsp_result(s3_rsp),
    .rsp_flags(s3_flags), .sticky_flags(s3_sticky), .clr_sticky(1'b0), .op_count(s3_cnt));

  // Transaction model: an accepted op completes SETTLE edges later, then waits for the consumer.
  int cyc, m_cap;
  logic m_busy, m_valid, m_ready, m_acc, m_do_cap;
  logic [2:0] m_op;
  logic [15:0] m_a, m_b, m_last, m_res, m_count;
  logic [3:0] m_flags, m_sticky, m_new;
  logic [18:0] m_r;
  always_comb begin
    m_r = alu_f(m_op, m_a, m_b);
    m_new = {m_r[18:16], m_r[15]};
    m_acc = m_ready && cmd_valid;
    m_do_cap = m_busy && (cyc + 1 == m_cap);
  end
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc <= 0; m_cap <= 0; m_busy <= 0; m_valid <= 0; m_ready <= 0;
      m_op <= 0; m_a <= 0; m_b <= 0; m_last <= 0; m_res <= 0; m_count <= 0; m_flags <= 0; m_sticky <= 0;
    end else begin
      cyc <= cyc + 1;
      if (m_do_cap) begin
        m_res <= m_r[15:0]; m_last <= m_r[15:0]; m_flags <= m_new; m_count <= m_count + 16'd1;
        m_valid <= 1; m_busy <= 0;
      end else if (m_valid && rsp_ready) m_valid <= 0;
      if (preload) m_count <= 16'hFFFF;
      m_sticky <= (clr_sticky ? 4'h0 : m_sticky) | (m_do_cap ? m_new : 4'h0);
      if (m_acc) begin
        m_busy <= 1; m_cap <= cyc + 1 + S; m_op <= cmd_op; m_b <= cmd_b;
        m_a <= cmd_chain ? m_last : cmd_a;
      end
      m_ready <= !(m_acc || (m_busy && !m_do_cap)) && !(m_do_cap || (m_valid && !rsp_ready));
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) if (rst_n) begin
    chk("cyc_cmd_ready", cmd_ready, m_ready);
    chk("cyc_rsp_valid", rsp_valid, m_valid);
    chk("cyc_rsp_result", rsp_result, m_res);
    chk("cyc_rsp_flags", rsp_flags, m_flags);
    chk("cyc_sticky", sticky_flags, m_sticky);
    chk("cyc_op_count", op_count, m_count);
    chk("cyc_alu_op", alu_op, m_op);
    chk("cyc_alu_a", alu_a, m_a);
    chk("cyc_alu_b", alu_b, m_b);
  end

  task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input logic ch);
    cmd_op = op; cmd_a = a; cmd_b = b; cmd_chain = ch; cmd_valid = 1;
    for (int i = 0; i < 20 && !cmd_ready; i++) @(negedge clk);
    chk("accept_wait", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0; cmd_op = 3'd5; cmd_a = 16'hDEAD; cmd_b = 16'hBEEF; cmd_chain = 0;
  endtask

  task automatic ack;
    for (int i = 0; i < 20 && !rsp_valid; i++) @(negedge clk);
    chk("rsp_wait", rsp_valid, 1);
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_op_count", op_count, 0);
    chk("rst_alu_a", alu_a, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", cmd_ready, 1);
    send(3'd0, 16'd100, 16'd120, 0);
    chk("basic_alu_a", alu_a, 16'd100);
    chk("basic_not_yet", rsp_valid, 0);
    @(negedge clk);
    chk("basic_valid", rsp_valid, 1);
    chk("basic_result", rsp_result, 16'h00DC);
    chk("basic_flags", rsp_flags, 4'b0000);
    chk("basic_count", op_count, 16'd1);
    chk("model_pin_basic", m_res, 16'h00DC);
    ack();
    send(3'd0, 16'd1, 16'd2, 0);
    @(negedge clk);
    cmd_op = 3'd0; cmd_a = 16'd3; cmd_b = 16'd4; cmd_valid = 1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_result", rsp_result, 16'd3);
      chk("bp_ready", cmd_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("bp_released", rsp_valid, 0);
    chk("bp_ready_back", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 0;
    chk("bp_second_taken", cmd_ready, 0);
    chk("bp_second_a", alu_a, 16'd3);
    @(negedge clk);
    chk("bp_second_result", rsp_result, 16'd7);
    ack();
    rsp_ready = 1;
    send(3'd1, 16'd10, 16'd3, 0);
    @(negedge clk);
    chk("early_ready_valid", rsp_valid, 1);
    chk("early_ready_result", rsp_result, 16'd7);
    @(negedge clk);
    chk("early_ready_done", rsp_valid, 0);
    rsp_ready = 0;
    chk("sticky_clean", sticky_flags, 4'h0);
    send(3'd0, 16'h7FFF, 16'h0001, 0);
    @(negedge clk);
    chk("ovf_result", rsp_result, 16'h8000);
    chk("ovf_flags", rsp_flags, 4'b1001);
    chk("model_pin_ovf", m_flags, 4'b1001);
    ack();
    send(3'd0, 16'd1, 16'd1, 0);
    ack();
    chk("sticky_kept", sticky_flags, 4'b1001);
    send(3'd0, 16'hFFFF, 16'h0001, 0);
    clr_sticky = 1;
    @(negedge clk);
    clr_sticky = 0;
    chk("wrap_flags", rsp_flags, 4'b0110);
    chk("clr_on_capture", sticky_flags, 4'b0110);
    chk("model_pin_sticky", m_sticky, 4'b0110);
    ack();
    clr_sticky = 1;
    @(negedge clk);
    clr_sticky = 0;
    chk("clr_idle", sticky_flags, 4'h0);
    send(3'd0, 16'd5, 16'd3, 0);
    ack();
    send(3'd0, 16'hAAAA, 16'd10, 1);
    chk("chain_alu_a", alu_a, 16'd8);
    @(negedge clk);
    chk("chain_result", rsp_result, 16'd18);
    ack();
    send(3'd0, 16'd1, 16'd1, 0);
    #2 rst_n = 0;
    #1;
    chk("abort_valid", rsp_valid, 0);
    chk("abort_count", op_count, 0);
    chk("abort_ready", cmd_ready, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    chk("abort_ready_back", cmd_ready, 1);
    send(3'd0, 16'h1234, 16'd5, 1);
    chk("chain_first_a", alu_a, 16'd0);
    @(negedge clk);
    chk("chain_first_result", rsp_result, 16'd5);
    chk("abort_count_after", op_count, 16'd1);
    ack();
    #2 force dut.op_count_q = 16'hFFFF;
    preload = 1;
    @(negedge clk);
    #2 release dut.op_count_q;
    preload = 0;
    chk("preload_count", op_count, 16'hFFFF);
    @(negedge clk);
    send(3'd0, 16'd2, 16'd2, 0);
    @(negedge clk);
    chk("count_wrap", op_count, 16'h0000);
    chk("count_wrap_result", rsp_result, 16'd4);
    ack();
    s3_op = 3'd0; s3_a = 16'h0102; s3_b = 16'h0304; s3_valid = 1;
    for (int i = 0; i < 20 && !s3_ready; i++) @(negedge clk);
    chk("s3_accept_wait", s3_ready, 1);
    @(negedge clk);
    s3_valid = 0; s3_a = 16'h0; s3_b = 16'h0; s3_op = 3'd4;
    for (int i = 0; i < 3; i++) begin
      chk("s3_not_yet", s3_rvalid, 0);
      chk("s3_hold_a", s3_alu_a, 16'h0102);
      chk("s3_hold_b", s3_alu_b, 16'h0304);
      chk("s3_hold_op", s3_alu_op, 3'd0);
      @(negedge clk);
    end
    chk("s3_valid", s3_rvalid, 1);
    chk("s3_result", s3_rsp, 16'h0406);
    chk("s3_hold_a_end", s3_alu_a, 16'h0102);
    chk("s3_count", s3_cnt, 16'd1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
